data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter W, default 8, width in bits of each memory entry.
REQ-002 Parameter A, default 8, address width; depth SHALL be 2**A entries.
REQ-003 Parameter CLR_VAL, default 0 (W bits), value written to every entry by a clear sweep.
REQ-004 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 ReqValid  input  1  request present.
REQ-007 ReqReady  output  1  block can accept a request this cycle.
REQ-008 ReqWrite  input  1  1 = write, 0 = read.
REQ-009 ReqAddr  input  A  entry address.
REQ-010 ReqData  input  W  write data.
REQ-011 ParityInject  input  1  with parity enabled, stores inverted parity on this write.
REQ-012 ClearStart  input  1  request a full clear sweep.
REQ-013 RspValid  output  1  one-cycle pulse, read data valid.
REQ-014 RspData  output  W  read data, registered.
REQ-015 Busy  output  1  clear sweep in progress.
REQ-016 ParityErr  output  1  parity mismatch on the read returned this cycle.

Function
REQ-017 FSM SHALL have two states, CLEAR and READY; ReqReady = (state == READY), registered, no input-to-output combinational path.
REQ-018 Request accepted on a rising edge with ReqValid && ReqReady; at most one access per cycle.
REQ-019 Accepted write SHALL update Core[ReqAddr] at that edge and produce no response.
REQ-020 Accepted read SHALL assert RspValid for exactly one cycle starting the next cycle, RspData = Core[ReqAddr] as of after that edge (1-cycle latency).
REQ-021 Read issued the cycle after a write to the same address SHALL return the new data.
REQ-022 RspData SHALL hold its last value when RspValid is low; no response backpressure.
REQ-023 CLEAR: counter ClrAddr writes CLR_VAL to Core[ClrAddr] each cycle, 0 to 2**A-1 ascending, then READY next cycle; sweep lasts exactly 2**A cycles.
REQ-024 Busy SHALL equal (state == CLEAR).
REQ-025 ClearStart in READY SHALL enter CLEAR with ClrAddr = 0 next cycle; a request accepted in that same cycle SHALL complete normally (read response still issued).
REQ-026 ClearStart while in CLEAR SHALL be ignored (no restart).
REQ-027 ReqValid during CLEAR SHALL not be accepted and SHALL not alter memory.
REQ-028 ClrAddr SHALL not wrap; CLEAR exits on the cycle after address 2**A-1.

Reset
REQ-029 Reset low SHALL immediately force state = CLEAR, ClrAddr = 0, RspValid = 0, RspData = 0, ParityErr = 0, ReqReady = 0, Busy = 1.
REQ-030 Memory array SHALL not be reset directly; the post-reset sweep initialises it.
REQ-031 Reset asserted mid-sweep or mid-read SHALL discard the operation; sweep restarts at 0 after release.

Configuration
REQ-032 Macro DATAMEM_PARITY_EN: when defined, each entry SHALL store W+1 bits (data plus even parity); clear writes correct parity.
REQ-033 With DATAMEM_PARITY_EN: ParityInject=1 on an accepted write SHALL store inverted parity; ParityErr SHALL pulse with RspValid when stored parity mismatches data.
REQ-034 Without DATAMEM_PARITY_EN: entries are W bits, ParityInject ignored, ParityErr constant 0; ports unchanged.

Verification (W=8, A=4, CLR_VAL=8'hA5)
REQ-035 Release Reset -> Busy=1, ReqReady=0 for exactly 16 cycles, then ReqReady=1; reads of 0..15 return 8'hA5.
REQ-036 Write 8'h3C to addr 5, read addr 5 next cycle -> RspValid one cycle later, RspData=8'h3C.
REQ-037 Read addr 7 with ClearStart same cycle -> RspData=8'hA5 next cycle, Busy=1 for 16 cycles, writes ignored meanwhile.
REQ-038 Reset low at sweep cycle 9 -> outputs at reset values at once; after release full 16-cycle sweep again.
REQ-039 Parity on: write 8'h01 with ParityInject=1 to addr 2, read -> ParityErr=1 with RspValid; parity off -> ParityErr=0.
REQ-040 Back-to-back reads addr 0,1,2 -> RspValid high 3 consecutive cycles, data in order.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory with a power-up/on-demand clear sweep
//
// Optional feature: define DATAMEM_PARITY_EN to store an even-parity bit per entry.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_ni           asynchronous active-low reset
//   req_valid_i      request present
//   req_ready_o      request can be accepted this cycle (registered)
//   req_write_i      1 = write, 0 = read
//   req_addr_i       entry address
//   req_data_i       write data
//   parity_inject_i  store inverted parity on this write (parity builds only)
//   clear_start_i    start a full clear sweep (ignored while sweeping)
//   rsp_valid_o      one-cycle pulse, read data valid
//   rsp_data_o       registered read data, holds while rsp_valid_o is low
//   busy_o           clear sweep in progress
//   parity_err_o     parity mismatch on the read returned this cycle
module data_mem_ctrl #(
    parameter int           W       = 8,
    parameter int           A       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_write_i,
    input  logic [A-1:0] req_addr_i,
    input  logic [W-1:0] req_data_i,
    input  logic         parity_inject_i,
    input  logic         clear_start_i,
    output logic         rsp_valid_o,
    output logic [W-1:0] rsp_data_o,
    output logic         busy_o,
    output logic         parity_err_o
);
`ifdef DATAMEM_PARITY_EN
    localparam int MW = W + 1;
`else
    localparam int MW = W;
`endif
    typedef enum logic {CLEAR, READY} state_t;
    state_t         state_q, state_d;
    logic [A-1:0]   clr_addr_q, clr_addr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           parity_err_q, parity_err_d;
    logic [MW-1:0]  mem [2**A];
    logic [MW-1:0]  wr_word, clr_word, rd_word;
    logic           accept, rd_en, wr_en, rd_err;

    assign accept  = req_valid_i && (state_q == READY);
    assign rd_en   = accept && !req_write_i;
    assign wr_en   = accept && req_write_i;
    assign rd_word = mem[req_addr_i];

`ifdef DATAMEM_PARITY_EN
    // Top bit holds even parity over the data; injection flips it.
    assign wr_word  = {(^req_data_i) ^ parity_inject_i, req_data_i};
    assign clr_word = {^CLR_VAL, CLR_VAL};
    assign rd_err   = ^rd_word;
`else
    logic unused_parity_inject;
    assign unused_parity_inject = parity_inject_i;
    assign wr_word  = req_data_i;
    assign clr_word = CLR_VAL;
    assign rd_err   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        rsp_valid_d  = rd_en;
        rsp_data_d   = rsp_data_q;
        parity_err_d = 1'b0;
        if (state_q == CLEAR) begin
            // Leave on the cycle after the last address instead of wrapping.
            state_d    = (clr_addr_q == '1) ? READY : CLEAR;
            clr_addr_d = (clr_addr_q == '1) ? '0 : clr_addr_q + A'(1);
        end else if (clear_start_i) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end
        if (rd_en) begin
            rsp_data_d   = rd_word[W-1:0];
            parity_err_d = rd_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            parity_err_q <= parity_err_d;
        end
    end

    // The array has no reset; the sweep that follows reset initialises it.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR)
            mem[clr_addr_q] <= clr_word;
        else if (wr_en)
            mem[req_addr_i] <= wr_word;
    end

    assign req_ready_o  = (state_q == READY);
    assign busy_o       = (state_q == CLEAR);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign parity_err_o = parity_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random checks of data_mem_ctrl against a behavioural model
module tb_data_mem_ctrl;
`ifdef DATAMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_write = 1'b0, parity_inject = 1'b0, clear_start = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, rsp_valid, busy, parity_err;
    logic [7:0] rsp_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] mm [16];
    bit         mc [16];
    int         clr_left = 16;
    logic       exp_rv = 1'b0, exp_pe = 1'b0;
    logic [7:0] exp_rd = '0;

    data_mem_ctrl #(.W(8), .A(4), .CLR_VAL(8'hA5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
        .parity_inject_i(parity_inject), .clear_start_i(clear_start),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .busy_o(busy), .parity_err_o(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("req_ready", req_ready, clr_left == 0);
        chk("busy", busy, clr_left != 0);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_data", rsp_data, exp_rd);
        chk("parity_err", parity_err, exp_pe);
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model at
    // the rising edge, then compare at the next falling edge.
    task automatic cyc(input logic v, input logic w, input logic [3:0] a,
                       input logic [7:0] d, input logic inj, input logic cs);
        logic acc;
        req_valid = v; req_write = w; req_addr = a; req_data = d;
        parity_inject = inj; clear_start = cs;
        @(posedge clk);
        acc    = v && (clr_left == 0);
        exp_rv = acc && !w;
        exp_pe = 1'b0;
        if (exp_rv) begin
            exp_rd = mm[a];
            exp_pe = PAR && mc[a];
        end
        if (acc && w) begin
            mm[a] = d;
            mc[a] = inj;
        end
        if (clr_left > 0) begin
            mm[16 - clr_left] = 8'hA5;
            mc[16 - clr_left] = 1'b0;
            clr_left--;
        end else if (cs) begin
            clr_left = 16;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    endtask

    // Asserted at a falling edge; outputs must reach reset values without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        clr_left = 16;
        exp_rv = 1'b0;
        exp_rd = '0;
        exp_pe = 1'b0;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b1, 4'(i), 8'h00, 1'b0, 1'b0);
        chk("ready_after_sweep", req_ready, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0);
            if (i > 0) chk("init_read_a5", rsp_data, 8'hA5);
        end
        idle();
        chk("init_read_last", rsp_data, 8'hA5);

        cyc(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0);
        idle();
        chk("raw_data", rsp_data, 8'h3C);
        idle();
        chk("rsp_pulse_one_cycle", rsp_valid, 1'b0);
        chk("rsp_data_hold", rsp_data, 8'h3C);

        cyc(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0);
        idle();

        cyc(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b1);
        chk("read_with_clear", rsp_data, 8'hA5);
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b1, 4'(i), 8'(i * 7 + 1), 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0);
        idle();

        cyc(1'b1, 1'b1, 4'd2, 8'h01, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0);
        chk("parity_err_inject", parity_err, PAR);
        cyc(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
        chk("parity_err_clean", parity_err, 1'b0);

        cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
        repeat (9) idle();
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b1, 4'(i), 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0);
        idle();

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
